// File: rtl/execute.sv
// EX stage: operand forwarding, ALU, branch resolution, EX/MEM pipe register.
// Ports: ID/EX bundle in, MEM/WB forwarding in, stall/flush in, EX/MEM bundle out.
module execute #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] Rd1_IDEX,
  input  logic [DW-1:0] Rd2_IDEX,
  input  logic [DW-1:0] Imm_IDEX,
  input  logic [DW-1:0] PC_IDEX,
  input  logic [3:0]    ALUOp_IDEX,
  input  logic          ALUSrc_IDEX,
  input  logic          Branch_IDEX,
  input  logic [1:0]    BrCond_IDEX,
  input  logic          MemtoReg_IDEX,
  input  logic          MemWrite_IDEX,
  input  logic          MemRead_IDEX,
  input  logic          Dump_IDEX,
  input  logic          RegWrite_IDEX,
  input  logic          Valid_IDEX,
  input  logic [2:0]    RsN_IDEX,
  input  logic [2:0]    RtN_IDEX,
  input  logic [2:0]    WrReg_IDEX,
  input  logic [DW-1:0] WrData_MEMWB,
  input  logic [2:0]    WrReg_MEMWB,
  input  logic          RegWrite_MEMWB,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] ALUO_EXMEM,
  output logic [DW-1:0] Rd2_EXMEM,
  output logic [DW-1:0] Imm_EXMEM,
  output logic          Branch_EXMEM,
  output logic          MemtoReg_EXMEM,
  output logic          MemWrite_EXMEM,
  output logic          MemRead_EXMEM,
  output logic          Dump_EXMEM,
  output logic          RegWrite_EXMEM,
  output logic          Valid_EXMEM,
  output logic [2:0]    WrReg_EXMEM,
  output logic          BrTaken_EXMEM,
  output logic [DW-1:0] BrTarget_EXMEM
);

  // A load in EX/MEM has no data yet, so it cannot forward.
  logic exFwdOk;
  logic exFwdA, exFwdB;
  logic wbFwdA, wbFwdB;
  logic [DW-1:0] opA, rd2Fwd, opB;

  assign exFwdOk = RegWrite_EXMEM & Valid_EXMEM & ~MemRead_EXMEM;
  assign exFwdA  = exFwdOk & (WrReg_EXMEM == RsN_IDEX);
  assign exFwdB  = exFwdOk & (WrReg_EXMEM == RtN_IDEX);
  assign wbFwdA  = RegWrite_MEMWB & (WrReg_MEMWB == RsN_IDEX);
  assign wbFwdB  = RegWrite_MEMWB & (WrReg_MEMWB == RtN_IDEX);

  assign opA = exFwdA ? ALUO_EXMEM :
               wbFwdA ? WrData_MEMWB : Rd1_IDEX;
  assign rd2Fwd = exFwdB ? ALUO_EXMEM :
                  wbFwdB ? WrData_MEMWB : Rd2_IDEX;
  assign opB = ALUSrc_IDEX ? Imm_IDEX : rd2Fwd;

  logic [3:0]    sh;
  logic [DW:0]   sum;
  logic          eq, lt;
  logic [DW-1:0] aluRes;

  assign sh  = opB[3:0];
  assign sum = {1'b0, opA} + {1'b0, opB};
  assign eq  = (opA == opB);
  assign lt  = ($signed(opA) < $signed(opB));

  always_comb begin
    aluRes = '0;
    unique case (ALUOp_IDEX)
      4'd0:  aluRes = sum[DW-1:0];
      4'd1:  aluRes = opA - opB;
      4'd2:  aluRes = opA & opB;
      4'd3:  aluRes = opA | opB;
      4'd4:  aluRes = opA ^ opB;
      4'd5:  aluRes = opA & ~opB;
      4'd6:  aluRes = opA << sh;
      4'd7:  aluRes = opA >> sh;
      4'd8:  aluRes = $signed(opA) >>> sh;
      4'd9:  aluRes = (opA << sh) | (opA >> (DW - sh));
      4'd10: aluRes = {{(DW-1){1'b0}}, eq};
      4'd11: aluRes = {{(DW-1){1'b0}}, lt};
      4'd12: aluRes = {{(DW-1){1'b0}}, lt | eq};
      4'd13: aluRes = {{(DW-1){1'b0}}, sum[DW]};
      4'd14: aluRes = opB;
      4'd15: aluRes = opA;
    endcase
  end

  logic brCond;

  always_comb begin
    brCond = 1'b0;
    unique case (BrCond_IDEX)
      2'b00: brCond = (opA == '0);
      2'b01: brCond = (opA != '0);
      2'b10: brCond = opA[DW-1];
      2'b11: brCond = ~opA[DW-1];
    endcase
  end

  // Data fields are don't-care in a bubble, so they load
  // whenever the stage is not held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUO_EXMEM     <= '0;
      Rd2_EXMEM      <= '0;
      Imm_EXMEM      <= '0;
      BrTarget_EXMEM <= '0;
      WrReg_EXMEM    <= '0;
      MemtoReg_EXMEM <= 1'b0;
    end else if (flush || !stall) begin
      ALUO_EXMEM     <= aluRes;
      Rd2_EXMEM      <= rd2Fwd;
      Imm_EXMEM      <= Imm_IDEX;
      BrTarget_EXMEM <= PC_IDEX + Imm_IDEX;
      WrReg_EXMEM    <= WrReg_IDEX;
      MemtoReg_EXMEM <= MemtoReg_IDEX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Valid_EXMEM    <= 1'b0;
      RegWrite_EXMEM <= 1'b0;
      MemWrite_EXMEM <= 1'b0;
      MemRead_EXMEM  <= 1'b0;
      Dump_EXMEM     <= 1'b0;
      Branch_EXMEM   <= 1'b0;
      BrTaken_EXMEM  <= 1'b0;
    end else if (flush || !stall) begin
      Valid_EXMEM    <= ~flush & Valid_IDEX;
      RegWrite_EXMEM <= ~flush & Valid_IDEX & RegWrite_IDEX;
      MemWrite_EXMEM <= ~flush & Valid_IDEX & MemWrite_IDEX;
      MemRead_EXMEM  <= ~flush & Valid_IDEX & MemRead_IDEX;
      Dump_EXMEM     <= ~flush & Valid_IDEX & Dump_IDEX;
      Branch_EXMEM   <= ~flush & Valid_IDEX & Branch_IDEX;
      BrTaken_EXMEM  <= ~flush & Valid_IDEX & Branch_IDEX & brCond;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the EX stage.
// Drives ID/EX and MEM/WB inputs, checks EX/MEM outputs after each edge.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PC_IDEX;
  logic [3:0]  ALUOp_IDEX;
  logic        ALUSrc_IDEX, Branch_IDEX;
  logic [1:0]  BrCond_IDEX;
  logic        MemtoReg_IDEX, MemWrite_IDEX, MemRead_IDEX;
  logic        Dump_IDEX, RegWrite_IDEX, Valid_IDEX;
  logic [2:0]  RsN_IDEX, RtN_IDEX, WrReg_IDEX;
  logic [15:0] WrData_MEMWB;
  logic [2:0]  WrReg_MEMWB;
  logic        RegWrite_MEMWB;
  logic        stall, flush;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM, Imm_EXMEM, BrTarget_EXMEM;
  logic        Branch_EXMEM, MemtoReg_EXMEM, MemWrite_EXMEM;
  logic        MemRead_EXMEM, Dump_EXMEM, RegWrite_EXMEM;
  logic        Valid_EXMEM, BrTaken_EXMEM;
  logic [2:0]  WrReg_EXMEM;

  int checks = 0;
  int failures = 0;

  execute #(.DW(16)) dut (
    .clk(clk), .rst(rst),
    .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX),
    .Imm_IDEX(Imm_IDEX), .PC_IDEX(PC_IDEX),
    .ALUOp_IDEX(ALUOp_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX),
    .Branch_IDEX(Branch_IDEX), .BrCond_IDEX(BrCond_IDEX),
    .MemtoReg_IDEX(MemtoReg_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .Dump_IDEX(Dump_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .Valid_IDEX(Valid_IDEX),
    .RsN_IDEX(RsN_IDEX), .RtN_IDEX(RtN_IDEX),
    .WrReg_IDEX(WrReg_IDEX),
    .WrData_MEMWB(WrData_MEMWB), .WrReg_MEMWB(WrReg_MEMWB),
    .RegWrite_MEMWB(RegWrite_MEMWB),
    .stall(stall), .flush(flush),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM),
    .Imm_EXMEM(Imm_EXMEM), .Branch_EXMEM(Branch_EXMEM),
    .MemtoReg_EXMEM(MemtoReg_EXMEM),
    .MemWrite_EXMEM(MemWrite_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .Dump_EXMEM(Dump_EXMEM),
    .RegWrite_EXMEM(RegWrite_EXMEM), .Valid_EXMEM(Valid_EXMEM),
    .WrReg_EXMEM(WrReg_EXMEM), .BrTaken_EXMEM(BrTaken_EXMEM),
    .BrTarget_EXMEM(BrTarget_EXMEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain valid register-writing ALU op.
  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [2:0] rs,
                       input logic [2:0] rt,
                       input logic [2:0] wr);
    ALUOp_IDEX = op;
    Rd1_IDEX = a;
    Rd2_IDEX = b;
    RsN_IDEX = rs;
    RtN_IDEX = rt;
    WrReg_IDEX = wr;
    Imm_IDEX = 16'h0;
    PC_IDEX = 16'h0;
    ALUSrc_IDEX = 1'b0;
    Branch_IDEX = 1'b0;
    BrCond_IDEX = 2'b00;
    MemtoReg_IDEX = 1'b0;
    MemWrite_IDEX = 1'b0;
    MemRead_IDEX = 1'b0;
    Dump_IDEX = 1'b0;
    RegWrite_IDEX = 1'b1;
    Valid_IDEX = 1'b1;
  endtask

  initial begin
    issue(4'd0, 16'h0, 16'h0, 3'd4, 3'd5, 3'd7);
    Valid_IDEX = 1'b0;
    WrData_MEMWB = 16'h0;
    WrReg_MEMWB = 3'd0;
    RegWrite_MEMWB = 1'b0;
    stall = 1'b0;
    flush = 1'b0;

    // Reset holds across edges
    tick();
    issue(4'd15, 16'hABCD, 16'h0, 3'd4, 3'd5, 3'd7);
    tick();
    chk("rst_aluo", ALUO_EXMEM, 32'h0);
    chk("rst_valid", Valid_EXMEM, 32'h0);
    chk("rst_wrreg", WrReg_EXMEM, 32'h0);
    rst = 1'b1;

    // First capture after release
    tick();
    chk("first_aluo", ALUO_EXMEM, 32'hABCD);
    chk("first_valid", Valid_EXMEM, 32'h1);

    // Arithmetic edges, no forwarding (dest r7)
    issue(4'd0, 16'hFFFF, 16'h0001, 3'd4, 3'd5, 3'd7);
    tick(); chk("add_wrap", ALUO_EXMEM, 32'h0000);
    issue(4'd13, 16'hFFFF, 16'h0001, 3'd4, 3'd5, 3'd7);
    tick(); chk("sco", ALUO_EXMEM, 32'h0001);
    issue(4'd8, 16'h8000, 16'h0004, 3'd4, 3'd5, 3'd7);
    tick(); chk("sra", ALUO_EXMEM, 32'hF800);
    issue(4'd9, 16'h8001, 16'h0001, 3'd4, 3'd5, 3'd7);
    tick(); chk("rol", ALUO_EXMEM, 32'h0003);
    issue(4'd11, 16'h8000, 16'h7FFF, 3'd4, 3'd5, 3'd7);
    tick(); chk("slt", ALUO_EXMEM, 32'h0001);
    issue(4'd11, 16'h7FFF, 16'h8000, 3'd4, 3'd5, 3'd7);
    tick(); chk("slt_neg", ALUO_EXMEM, 32'h0000);
    issue(4'd12, 16'h0005, 16'h0005, 3'd4, 3'd5, 3'd7);
    tick(); chk("sle_eq", ALUO_EXMEM, 32'h0001);
    issue(4'd1, 16'h0003, 16'h0005, 3'd4, 3'd5, 3'd7);
    tick(); chk("sub", ALUO_EXMEM, 32'hFFFE);
    issue(4'd5, 16'hF0F0, 16'hFF00, 3'd4, 3'd5, 3'd7);
    tick(); chk("andn", ALUO_EXMEM, 32'h00F0);
    issue(4'd7, 16'h8000, 16'h000F, 3'd4, 3'd5, 3'd7);
    tick(); chk("srl", ALUO_EXMEM, 32'h0001);
    issue(4'd14, 16'h1111, 16'h2222, 3'd4, 3'd5, 3'd7);
    ALUSrc_IDEX = 1'b1;
    Imm_IDEX = 16'h00AB;
    tick(); chk("passb_imm", ALUO_EXMEM, 32'h00AB);

    // EX/MEM forwarding on A
    issue(4'd0, 16'h0003, 16'h0004, 3'd4, 3'd5, 3'd1);
    tick(); chk("fwd_add", ALUO_EXMEM, 32'h0007);
    issue(4'd1, 16'h0000, 16'h0002, 3'd1, 3'd2, 3'd3);
    tick(); chk("fwd_sub", ALUO_EXMEM, 32'h0005);

    // Store data forwarded on B despite ALUSrc
    issue(4'd0, 16'h0001, 16'h0000, 3'd4, 3'd3, 3'd0);
    ALUSrc_IDEX = 1'b1;
    Imm_IDEX = 16'h0010;
    RegWrite_IDEX = 1'b0;
    MemWrite_IDEX = 1'b1;
    tick();
    chk("st_aluo", ALUO_EXMEM, 32'h0011);
    chk("st_rd2", Rd2_EXMEM, 32'h0005);
    chk("st_memw", MemWrite_EXMEM, 32'h1);

    // Double hazard: EX/MEM wins
    issue(4'd0, 16'h1111, 16'h0000, 3'd4, 3'd5, 3'd2);
    tick();
    WrData_MEMWB = 16'h2222;
    WrReg_MEMWB = 3'd2;
    RegWrite_MEMWB = 1'b1;
    issue(4'd15, 16'h0000, 16'h0000, 3'd2, 3'd5, 3'd5);
    tick(); chk("dbl_exmem", ALUO_EXMEM, 32'h1111);

    // Load in EX/MEM cannot forward: MEM/WB used
    issue(4'd0, 16'h1111, 16'h0000, 3'd4, 3'd5, 3'd2);
    MemRead_IDEX = 1'b1;
    tick();
    issue(4'd15, 16'h0000, 16'h0000, 3'd2, 3'd5, 3'd5);
    tick(); chk("dbl_load", ALUO_EXMEM, 32'h2222);
    RegWrite_MEMWB = 1'b0;

    // Branches
    issue(4'd0, 16'hFFFE, 16'h0000, 3'd4, 3'd5, 3'd0);
    RegWrite_IDEX = 1'b0;
    Branch_IDEX = 1'b1;
    BrCond_IDEX = 2'b10;
    PC_IDEX = 16'h0010;
    Imm_IDEX = 16'hFFF0;
    tick();
    chk("br_taken", BrTaken_EXMEM, 32'h1);
    chk("br_target", BrTarget_EXMEM, 32'h0000);
    Rd1_IDEX = 16'h0001;
    tick(); chk("br_not", BrTaken_EXMEM, 32'h0);
    BrCond_IDEX = 2'b01;
    tick(); chk("bnez", BrTaken_EXMEM, 32'h1);
    Rd1_IDEX = 16'h0000;
    BrCond_IDEX = 2'b00;
    tick(); chk("beqz", BrTaken_EXMEM, 32'h1);
    Branch_IDEX = 1'b0;
    tick(); chk("nobr", BrTaken_EXMEM, 32'h0);

    // Stall holds through changing inputs
    issue(4'd0, 16'h1234, 16'h0000, 3'd4, 3'd5, 3'd6);
    tick(); chk("pre_stall", ALUO_EXMEM, 32'h1234);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(4'd0, 16'h4000 + 16'(i), 16'h0001, 3'd4, 3'd5, 3'd1);
      MemWrite_IDEX = 1'b1;
      tick();
      chk("stall_aluo", ALUO_EXMEM, 32'h1234);
      chk("stall_wr", WrReg_EXMEM, 32'h6);
      chk("stall_memw", MemWrite_EXMEM, 32'h0);
    end

    // Flush beats stall
    flush = 1'b1;
    tick();
    chk("flush_valid", Valid_EXMEM, 32'h0);
    chk("flush_memw", MemWrite_EXMEM, 32'h0);
    chk("flush_regw", RegWrite_EXMEM, 32'h0);
    flush = 1'b0;
    stall = 1'b0;

    // Valid=0 loads a bubble
    issue(4'd0, 16'h0001, 16'h0001, 3'd4, 3'd5, 3'd1);
    tick(); chk("live_valid", Valid_EXMEM, 32'h1);
    Valid_IDEX = 1'b0;
    tick();
    chk("bub_valid", Valid_EXMEM, 32'h0);
    chk("bub_regw", RegWrite_EXMEM, 32'h0);

    // Asynchronous reset mid-cycle while stalled
    issue(4'd0, 16'h1234, 16'h0000, 3'd4, 3'd5, 3'd6);
    tick();
    chk("prerst_aluo", ALUO_EXMEM, 32'h1234);
    stall = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_aluo", ALUO_EXMEM, 32'h0);
    chk("arst_valid", Valid_EXMEM, 32'h0);
    chk("arst_wrreg", WrReg_EXMEM, 32'h0);
    chk("arst_regw", RegWrite_EXMEM, 32'h0);
    #3 rst = 1'b1;
    tick();
    chk("post_rst", ALUO_EXMEM, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter DW, default 16, datapath width; all data ports below are DW bits wide.
REQ-002 SHALL have ports: clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-low reset).
REQ-003 SHALL have ID/EX operand inputs: Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PC_IDEX (in, DW, operand A, operand B, sign-extended immediate, PC+2).
REQ-004 SHALL have ID/EX control inputs:
- ALUOp_IDEX (in, 4);
- ALUSrc_IDEX (in, 1; 1 = B is Imm);
- Branch_IDEX (in, 1);
- BrCond_IDEX (in, 2);
- MemtoReg_IDEX, MemWrite_IDEX, MemRead_IDEX, Dump_IDEX, RegWrite_IDEX (in, 1 each);
- Valid_IDEX (in, 1).
REQ-005 SHALL have register-number inputs: RsN_IDEX, RtN_IDEX, WrReg_IDEX (in, 3, source A, source B, destination).
REQ-006 SHALL have writeback forwarding inputs: WrData_MEMWB (in, DW), WrReg_MEMWB (in, 3), RegWrite_MEMWB (in, 1).
REQ-007 SHALL have hazard inputs: stall (in, 1; hold the EX/MEM register) and flush (in, 1; insert a bubble).
REQ-008 SHALL have EX/MEM outputs:
- ALUO_EXMEM, Rd2_EXMEM, Imm_EXMEM (out, DW);
- Branch_EXMEM, MemtoReg_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, Dump_EXMEM, RegWrite_EXMEM, Valid_EXMEM (out, 1 each);
- WrReg_EXMEM (out, 3).
REQ-009 SHALL have branch outputs: BrTaken_EXMEM (out, 1) and BrTarget_EXMEM (out, DW), both registered.

Function
REQ-010 SHALL select each operand by forwarding priority:
- first, EX/MEM when RegWrite_EXMEM & Valid_EXMEM & !MemRead_EXMEM & WrReg_EXMEM matches;
- otherwise, MEM/WB when RegWrite_MEMWB & WrReg_MEMWB matches;
- otherwise, the ID/EX register value.
REQ-011 SHALL apply the forwarded Rd2 value to Rd2_EXMEM (store data) regardless of ALUSrc_IDEX.
REQ-012 SHALL compute the ALU result combinationally from A and B (B = Imm_IDEX when ALUSrc_IDEX = 1). ALUOp encodings:
- 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 ANDN (A&~B);
- 6 SLL, 7 SRL, 8 SRA, 9 ROL, each by B[3:0];
- 10 SEQ; 11 SLT (signed); 12 SLE (signed); 13 SCO (carry-out of A+B);
- 14 PASSB; 15 PASSA.
REQ-013 SHALL perform all arithmetic modulo 2^DW. SEQ, SLT, SLE and SCO SHALL return 0x0001 or 0x0000.
REQ-014 SHALL compute SLT/SLE without overflow error, e.g. A=0x8000, B=0x7FFF gives SLT=1.
REQ-015 SHALL evaluate the branch condition on forwarded A: BrCond 00 = A==0; 01 = A!=0; 10 = A<0 (signed); 11 = A>=0 (signed).
REQ-016 SHALL compute BrTarget = PC_IDEX + Imm_IDEX, mod 2^DW.
REQ-017 SHALL register all EX/MEM outputs on the rising clk edge, one cycle after the inputs; no combinational path from inputs to any output.
REQ-018 SHALL, when flush=1, clear on the next edge: Valid_EXMEM, RegWrite_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, Dump_EXMEM, Branch_EXMEM and BrTaken_EXMEM. Data outputs are don't-care.
REQ-019 SHALL, when stall=1 and flush=0, hold every EX/MEM output unchanged.
REQ-020 SHALL give flush priority over stall when both are 1.
REQ-021 SHALL, when Valid_IDEX=0 (no stall, no flush), load a bubble identical to REQ-018.
REQ-022 SHALL set BrTaken_EXMEM = Valid_IDEX & Branch_IDEX & condition-true; BrTaken_EXMEM SHALL be 0 for non-branch instructions.
REQ-023 SHALL use the pre-edge EX/MEM outputs for same-cycle forwarding (back-to-back dependent ops forward from the EX/MEM register).

Reset
REQ-024 SHALL, on rst low, asynchronously drive every output to 0 (all data to 0x0000, all control bits and WrReg_EXMEM to 0), independent of clk.
REQ-025 SHALL hold reset values while rst is low; the first capture occurs on the first rising clk edge after rst goes high.
REQ-026 SHALL, on reset mid-operation, discard any held (stalled) contents; no state survives reset.

Verification
REQ-027 Forwarding: ADD r1 (A=0x0003, B=0x0004) then SUB with RsN=r1, Rd1_IDEX stale 0x0000, B=0x0002 -> ALUO_EXMEM 0x0007 then 0x0005.
REQ-028 Double hazard: EX/MEM and MEM/WB both write r2 (EX/MEM result 0x1111, WrData_MEMWB 0x2222) -> consumer sees 0x1111. With MemRead_EXMEM=1 -> consumer sees 0x2222.
REQ-029 Arithmetic edges:
- ADD 0xFFFF+0x0001 -> ALUO 0x0000;
- SCO 0xFFFF,0x0001 -> 0x0001;
- SRA 0x8000 by 4 -> 0xF800;
- ROL 0x8001 by 1 -> 0x0003;
- SLT 0x8000,0x7FFF -> 0x0001.
REQ-030 Branch: BrCond=10, A=0xFFFE, PC_IDEX=0x0010, Imm=0xFFF0 -> BrTaken_EXMEM=1, BrTarget_EXMEM=0x0000. Same with A=0x0001 -> BrTaken_EXMEM=0.
REQ-031 Stall/flush: stall=1 for 3 cycles with changing inputs -> outputs constant. stall=1 and flush=1 together -> Valid_EXMEM=0, MemWrite_EXMEM=0 next edge.
REQ-032 Reset: assert rst low between clock edges while Valid_EXMEM=1 and ALUO_EXMEM=0x1234 -> all outputs 0 immediately, before the next edge.
